// File: rtl/inp_cancel_buy_servicer.sv
// inp_cancel_buy_servicer: services edge-capture PIO interrupts (read/clear capture, sample pin, report).
// Bus outputs are pure state decodes so the slave never sees a combinational path from irq/readdata.
module inp_cancel_buy_servicer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             irq,
    input  logic             readdata,
    output logic [1:0]       address,
    output logic             chipselect,
    output logic             write_n,
    output logic             writedata,
    output logic             event_pulse,
    output logic             level,
    output logic [CNT_W-1:0] event_count,
    output logic             busy
);
    typedef enum logic [3:0] {
        BOOT, MASK, IDLE, RD_CAP, WAIT_CAP, CLR_CAP, RD_DATA, WAIT_DATA, REPORT
    } state_e;

    state_e             state_q, state_d;
    logic               level_q, level_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            level_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:      state_d = MASK;
            MASK:      state_d = IDLE;
            IDLE:      state_d = (irq && enable) ? RD_CAP : IDLE;
            RD_CAP:    state_d = WAIT_CAP;
            WAIT_CAP:  state_d = readdata ? CLR_CAP : IDLE;
            CLR_CAP:   state_d = RD_DATA;
            RD_DATA:   state_d = WAIT_DATA;
            WAIT_DATA: state_d = REPORT;
            REPORT:    state_d = IDLE;
            default:   state_d = BOOT;
        endcase
    end

    // Address stays on the capture register through WAIT_CAP so the read is not disturbed.
    always_comb begin
        chipselect  = state_q inside {MASK, RD_CAP, CLR_CAP, RD_DATA};
        write_n     = !(state_q inside {MASK, CLR_CAP});
        writedata   = state_q == MASK;
        address     = (state_q == MASK) ? 2'd2 :
                      (state_q inside {RD_CAP, WAIT_CAP, CLR_CAP}) ? 2'd3 : 2'd0;
        event_pulse = state_q == REPORT;
        busy        = state_q != IDLE;
        level_d     = (state_q == WAIT_DATA) ? readdata : level_q;
        count_d     = (state_q == REPORT && !(&count_q)) ? count_q + CNT_W'(1) : count_q;
    end

    assign level       = level_q;
    assign event_count = count_q;
endmodule

// File: tb/tb_inp_cancel_buy_servicer.sv
// tb_inp_cancel_buy_servicer: directed bench with an edge-capture PIO slave model and
// scoreboards of expected bus operations and expected event levels.
module tb_inp_cancel_buy_servicer;
    localparam int CNT_W = 8;
    localparam logic [31:0] MAXC = 32'(2**CNT_W - 1);

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b1;
    logic             irq;
    logic             readdata;
    logic [1:0]       address;
    logic             chipselect, write_n, writedata, event_pulse, level, busy;
    logic [CNT_W-1:0] event_count;

    logic in_port = 1'b0, force_irq = 1'b0;
    logic in_prev, mask_q, cap_q;

    int checks = 0, errors = 0;
    logic [31:0] exp_cnt = 0;
    logic [31:0] bus_q[$];
    logic        lvl_q[$];
    logic        pulsed;
    int          n;

    always #5 clk = ~clk;

    inp_cancel_buy_servicer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .irq(irq), .readdata(readdata),
        .address(address), .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .event_pulse(event_pulse), .level(level), .event_count(event_count), .busy(busy)
    );

    // Edge-capture PIO slave: registered read data, clear beats a simultaneous new edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_prev  <= 1'b0;
            mask_q   <= 1'b0;
            cap_q    <= 1'b0;
            readdata <= 1'b0;
        end else begin
            in_prev <= in_port;
            if (chipselect && !write_n && address == 2'd2) mask_q <= writedata;
            if (chipselect && !write_n && address == 2'd3) cap_q <= 1'b0;
            else if (in_port && !in_prev) cap_q <= 1'b1;
            if (chipselect && write_n)
                readdata <= (address == 2'd0) ? in_port :
                            (address == 2'd2) ? mask_q :
                            (address == 2'd3) ? cap_q : 1'b0;
        end
    end
    assign irq = force_irq | (cap_q & mask_q);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic lvl);
        bus_q.push_back(32'b0_11_0);
        bus_q.push_back(32'b1_11_0);
        bus_q.push_back(32'b0_00_0);
        lvl_q.push_back(lvl);
    endtask

    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        pulsed = 1'b0;
        if (chipselect) begin
            chk("bus_pending", 32'(bus_q.size() != 0), 1);
            if (bus_q.size() != 0) begin
                e = bus_q.pop_front();
                chk("bus_op", {28'b0, ~write_n, address, ~write_n & writedata}, e);
            end
        end
        if (event_pulse) begin
            pulsed = 1'b1;
            chk("pulse_pending", 32'(lvl_q.size() != 0), 1);
            if (lvl_q.size() != 0) begin
                chk("level", 32'(level), 32'(lvl_q.pop_front()));
                chk("count_at_pulse", 32'(event_count), exp_cnt);
                exp_cnt = (exp_cnt == MAXC) ? MAXC : exp_cnt + 1;
            end
        end
    endtask

    task automatic wait_pulse(input int max, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!pulsed && cnt < max);
        chk("pulse_seen", 32'(pulsed), 1);
    endtask

    task automatic edge_up();
        in_port = 1'b0;
        tick();
        in_port = 1'b1;
    endtask

    initial begin
        // reset state and boot mask write
        tick();
        chk("rst_cs", 32'(chipselect), 0);
        chk("rst_wn", 32'(write_n), 1);
        chk("rst_addr", 32'(address), 0);
        chk("rst_wd", 32'(writedata), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_pulse", 32'(event_pulse), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_count", 32'(event_count), 0);
        bus_q.push_back(32'b1_10_1);
        reset_n = 1'b1;
        tick();
        chk("mask_busy", 32'(busy), 1);
        chk("mask_done", 32'(bus_q.size()), 0);
        tick();
        chk("idle_busy", 32'(busy), 0);
        repeat (3) tick();

        // single event with latency
        push_seq(1'b1);
        in_port = 1'b1;
        tick();
        chk("n_irq", 32'(irq), 1);
        chk("n_idle", 32'(busy), 0);
        wait_pulse(12, n);
        chk("latency", 32'(n), 6);
        tick();
        chk("count1", 32'(event_count), 1);
        chk("level1", 32'(level), 1);
        chk("idle_after", 32'(busy), 0);

        // spurious irq: capture reads 0, no clear, no report
        bus_q.push_back(32'b0_11_0);
        force_irq = 1'b1;
        tick();
        tick();
        force_irq = 1'b0;
        repeat (4) tick();
        chk("spur_count", 32'(event_count), 1);
        chk("spur_idle", 32'(busy), 0);
        chk("spur_bus", 32'(bus_q.size()), 0);

        // back-to-back: edge during service restarts immediately; second sees pin low
        push_seq(1'b1);
        push_seq(1'b0);
        edge_up();
        repeat (6) tick();
        in_port = 1'b0;
        tick();
        chk("b2b_pulse1", 32'(pulsed), 1);
        in_port = 1'b1;
        tick();
        chk("b2b_irq", 32'(irq), 1);
        chk("b2b_idle", 32'(busy), 0);
        tick();
        chk("b2b_restart", 32'(busy), 1);
        repeat (2) tick();
        in_port = 1'b0;
        wait_pulse(8, n);
        tick();
        chk("b2b_level0", 32'(level), 0);
        chk("b2b_count", 32'(event_count), 3);

        // enable low holds off servicing while irq pends
        enable = 1'b0;
        edge_up();
        repeat (5) tick();
        chk("dis_irq", 32'(irq), 1);
        chk("dis_idle", 32'(busy), 0);
        push_seq(1'b1);
        enable = 1'b1;
        wait_pulse(10, n);
        tick();

        // enable dropped during WAIT_CAP: sequence completes, then holds idle
        push_seq(1'b1);
        edge_up();
        repeat (3) tick();
        chk("wc_addr", 32'(address), 3);
        enable = 1'b0;
        wait_pulse(8, n);
        force_irq = 1'b1;
        repeat (4) tick();
        chk("hold_idle", 32'(busy), 0);
        chk("hold_count", 32'(event_count), 5);
        force_irq = 1'b0;
        enable = 1'b1;

        // saturation over 300 events
        for (int i = 0; i < 300; i++) begin
            push_seq(1'b1);
            edge_up();
            wait_pulse(10, n);
        end
        tick();
        chk("sat_count", 32'(event_count), MAXC);

        // reset during RD_DATA discards the sequence
        bus_q.push_back(32'b0_11_0);
        bus_q.push_back(32'b1_11_0);
        bus_q.push_back(32'b0_00_0);
        edge_up();
        repeat (5) tick();
        chk("rd_data_state", 32'(address), 0);
        chk("rd_data_cs", 32'(chipselect), 1);
        in_port = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_cs", 32'(chipselect), 0);
        chk("mid_rst_wn", 32'(write_n), 1);
        chk("mid_rst_busy", 32'(busy), 1);
        chk("mid_rst_count", 32'(event_count), 0);
        chk("mid_rst_level", 32'(level), 0);
        exp_cnt = 0;
        tick();
        bus_q.push_back(32'b1_10_1);
        reset_n = 1'b1;
        tick();
        tick();
        chk("reboot_idle", 32'(busy), 0);
        repeat (6) tick();
        chk("reboot_count", 32'(event_count), 0);
        chk("bus_drained", 32'(bus_q.size()), 0);
        chk("lvl_drained", 32'(lvl_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
